// File: rtl/ysyx_23060184_bus_arbiter_pkg.sv
// Shared bus definitions for the IFU/LSU arbiter: widths, default watchdog
// limit, FSM and master encodings, and the CLINT window the LSU crossbar decodes.
package ysyx_23060184_bus_arbiter_pkg;

  localparam int BUS_ADDR_W  = 32;
  localparam int BUS_DATA_W  = 32;
  localparam int BUS_TIMEOUT = 255;

  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_LAST = 32'h0200_ffff;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    M_IFU = 1'b0,
    M_LSU = 1'b1
  } master_e;

  // Round-robin on contention: the master that did not win last time goes next.
  function automatic master_e pick_winner(input logic ifu_req, input logic lsu_req,
                                          input master_e last_grant);
    if (ifu_req && lsu_req) return (last_grant == M_IFU) ? M_LSU : M_IFU;
    return lsu_req ? M_LSU : M_IFU;
  endfunction

  function automatic logic in_clint(input logic [31:0] addr);
    return (addr >= CLINT_BASE) && (addr <= CLINT_LAST);
  endfunction

endpackage

// File: rtl/ysyx_23060184_bus_watchdog.sv
// Transaction watchdog: counts owned cycles and flags the last cycle a
// transaction is allowed to run before the arbiter aborts it.
module ysyx_23060184_bus_watchdog
  import ysyx_23060184_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = BUS_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wd_cnt;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_wd_cnt <= '0;
    end else if (i_enable) begin
      r_wd_cnt <= r_wd_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_enable && (r_wd_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_23060184_bus_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory bus arbiter with alternating
// priority, one outstanding transaction and a watchdog abort path.
module ysyx_23060184_bus_arbiter
  import ysyx_23060184_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = BUS_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_done,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  output logic                ifu_grant,

  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_done,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                lsu_grant,

  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err
);

  state_e  r_state;
  master_e r_last_grant;
  logic    r_ifu_grant;
  logic    r_lsu_grant;

  logic              w_in_idle;
  logic              w_in_addr;
  logic              w_in_data;
  logic              w_start;
  logic              w_resp;
  logic              w_expire;
  logic              w_abort;
  logic              w_finish;
  logic              w_rsp_err;
  logic [DATA_W-1:0] w_rsp_data;
  master_e           w_winner;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_in_addr = (r_state == ST_ADDR);
  assign w_in_data = (r_state == ST_DATA);
  assign w_start   = w_in_idle && (ifu_req || lsu_req);
  assign w_winner  = pick_winner(ifu_req, lsu_req, r_last_grant);

  // A zero-wait slave may answer in the address cycle itself.
  assign w_resp   = (w_in_addr && mem_ready && mem_resp_valid) ||
                    (w_in_data && mem_resp_valid);
  assign w_abort  = w_expire && !w_resp;
  assign w_finish = (w_resp || w_abort) && !reset;

  assign w_rsp_data = w_resp ? mem_rdata : '0;
  assign w_rsp_err  = w_resp ? mem_resp_err : 1'b1;

  ysyx_23060184_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_start),
    .i_enable (w_in_addr || w_in_data),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= M_IFU;
      r_ifu_grant  <= 1'b0;
      r_lsu_grant  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state      <= ST_ADDR;
            r_last_grant <= w_winner;
            r_ifu_grant  <= (w_winner == M_IFU);
            r_lsu_grant  <= (w_winner == M_LSU);
          end
        end
        ST_ADDR: begin
          if (w_finish) begin
            r_state     <= ST_IDLE;
            r_ifu_grant <= 1'b0;
            r_lsu_grant <= 1'b0;
          end else if (mem_ready) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_finish) begin
            r_state     <= ST_IDLE;
            r_ifu_grant <= 1'b0;
            r_lsu_grant <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ifu_grant <= 1'b0;
          r_lsu_grant <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a default before the branches,
  // otherwise the unassigned paths would infer latches.
  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (w_in_addr) begin
      mem_valid = 1'b1;
      if (r_lsu_grant) begin
        mem_we    = lsu_we;
        mem_addr  = lsu_addr;
        mem_wdata = lsu_wdata;
        mem_wmask = lsu_wmask;
      end else begin
        mem_addr  = ifu_addr;
      end
    end
  end

  assign ifu_grant = r_ifu_grant;
  assign lsu_grant = r_lsu_grant;

  assign ifu_done  = r_ifu_grant && w_finish;
  assign ifu_rdata = ifu_done ? w_rsp_data : '0;
  assign ifu_err   = ifu_done && w_rsp_err;

  assign lsu_done  = r_lsu_grant && w_finish;
  assign lsu_rdata = lsu_done ? w_rsp_data : '0;
  assign lsu_err   = lsu_done && w_rsp_err;

endmodule

// File: tb/tb_ysyx_23060184_bus_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random masters and bus, all compared each cycle against a transaction model.
module tb_ysyx_23060184_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          ifu_req;
  logic [AW-1:0] ifu_addr;
  logic          ifu_done;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_err;
  logic          ifu_grant;
  logic          lsu_req;
  logic          lsu_we;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wmask;
  logic          lsu_done;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_err;
  logic          lsu_grant;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_ready;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;
  logic          mem_resp_err;

  always #5 clock = ~clock;

  ysyx_23060184_bus_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_req        (ifu_req),
    .ifu_addr       (ifu_addr),
    .ifu_done       (ifu_done),
    .ifu_rdata      (ifu_rdata),
    .ifu_err        (ifu_err),
    .ifu_grant      (ifu_grant),
    .lsu_req        (lsu_req),
    .lsu_we         (lsu_we),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .lsu_err        (lsu_err),
    .lsu_grant      (lsu_grant),
    .mem_valid      (mem_valid),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_ready      (mem_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .mem_resp_err   (mem_resp_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: who owns the bus, how long it has owned it,
  // and whether the address phase has been accepted yet.
  int m_owner = 0;   // 0 none, 1 IFU, 2 LSU
  int m_age   = 0;
  bit m_acc   = 1'b0;
  int m_last  = 1;
  bit m_ifu_done_prev = 1'b0;
  bit m_lsu_done_prev = 1'b0;

  task automatic model_cycle();
    bit e_ig, e_lg, e_valid, resp, abort, fin, er;
    logic [DW-1:0] rd;
    e_ig    = (m_owner == 1);
    e_lg    = (m_owner == 2);
    e_valid = (m_owner != 0) && !m_acc;
    resp    = (m_owner != 0) && ((!m_acc && mem_ready && mem_resp_valid) ||
                                 (m_acc && mem_resp_valid));
    abort   = (m_owner != 0) && !resp && (m_age == TMO - 1);
    fin     = (resp || abort) && !reset;
    rd      = resp ? mem_rdata : 32'h0;
    er      = resp ? mem_resp_err : 1'b1;

    check("grants", {ifu_grant, lsu_grant}, {e_ig, e_lg});
    check("mem_valid", mem_valid, e_valid);
    if (e_valid)
      check("mem_req", {mem_we, mem_wmask, mem_addr, (e_lg ? mem_wdata : 32'h0)},
            {(e_lg ? lsu_we : 1'b0), (e_lg ? lsu_wmask : 4'h0),
             (e_lg ? lsu_addr : ifu_addr), (e_lg ? lsu_wdata : 32'h0)});
    check("ifu_resp", {ifu_done, ifu_err, ifu_rdata},
          {fin && e_ig, fin && e_ig && er, ((fin && e_ig) ? rd : 32'h0)});
    check("lsu_resp", {lsu_done, lsu_err, lsu_rdata},
          {fin && e_lg, fin && e_lg && er, ((fin && e_lg) ? rd : 32'h0)});

    m_ifu_done_prev = fin && e_ig;
    m_lsu_done_prev = fin && e_lg;

    if (reset) begin
      m_owner = 0; m_age = 0; m_acc = 1'b0; m_last = 1;
    end else if (m_owner == 0) begin
      if (ifu_req || lsu_req) begin
        if (ifu_req && lsu_req) m_owner = (m_last == 1) ? 2 : 1;
        else                    m_owner = lsu_req ? 2 : 1;
        m_last = m_owner; m_age = 0; m_acc = 1'b0;
      end
    end else if (fin) begin
      m_owner = 0;
    end else begin
      m_age++;
      if (!m_acc && mem_ready) m_acc = 1'b1;
    end
  endtask

  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      model_cycle();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    tick();
    tick();
    @(negedge clock);
    check("reset_outs", |{ifu_done, ifu_rdata, ifu_err, ifu_grant, lsu_done, lsu_rdata,
                          lsu_err, lsu_grant, mem_valid, mem_we, mem_addr, mem_wdata,
                          mem_wmask}, 1'b0);

    // First tie after reset, sustained requests on a zero-wait bus.
    tick();
    reset = 1'b0;
    ifu_req = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req = 1'b1; lsu_addr = 32'h8000_1000;
    mem_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hA5A5_0000;
    @(negedge clock);
    check("tie_idle", {ifu_grant, lsu_grant}, 2'b00);
    for (int k = 1; k <= 7; k++) begin
      tick();
      @(negedge clock);
      if (k % 2 == 1) begin
        check("alt_grant", {ifu_grant, lsu_grant}, ((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
        check("alt_done", {ifu_done, lsu_done}, ((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
      end else begin
        check("alt_gap", {ifu_grant, lsu_grant, ifu_done, lsu_done}, 4'b0000);
      end
    end
    tick();
    ifu_req = 1'b0; lsu_req = 1'b0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

    // IFU alone: ready one cycle after valid, response two cycles later.
    tick();
    ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
    @(negedge clock);
    check("t1_c0_grant", ifu_grant, 1'b0);
    tick();
    @(negedge clock);
    check("t1_c1", {ifu_grant, lsu_grant, mem_valid, mem_addr}, {3'b101, 32'h8000_0000});
    tick();
    mem_ready = 1'b1;
    @(negedge clock);
    check("t1_c2_valid", mem_valid, 1'b1);
    tick();
    mem_ready = 1'b0;
    @(negedge clock);
    check("t1_c3", {mem_valid, ifu_done, ifu_grant}, 3'b001);
    tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    check("t1_done", {ifu_done, ifu_err, ifu_rdata, lsu_grant}, {2'b10, 32'hDEAD_BEEF, 1'b0});
    tick();
    ifu_req = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    @(negedge clock);
    check("t1_release", ifu_grant, 1'b0);

    // LSU write to the CLINT window.
    tick();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h0200_0000;
    lsu_wdata = 32'h0000_1234; lsu_wmask = 4'h3;
    tick();
    mem_ready = 1'b1;
    @(negedge clock);
    check("t3_fields", {lsu_grant, mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, lsu_done},
          {3'b111, 32'h0200_0000, 32'h0000_1234, 4'h3, 1'b0});
    tick();
    mem_ready = 1'b0; mem_resp_valid = 1'b1;
    @(negedge clock);
    check("t3_ack", {lsu_done, lsu_err}, 2'b10);
    tick();
    lsu_req = 1'b0; lsu_we = 1'b0; mem_resp_valid = 1'b0;

    // Hung bus: watchdog abort, then a late stray response.
    tick();
    lsu_req = 1'b1; lsu_addr = 32'h8000_2000; mem_rdata = 32'h55AA_55AA;
    for (int k = 1; k <= 7; k++) begin
      tick();
      @(negedge clock);
      check("t4_wait", {lsu_grant, lsu_done}, 2'b10);
    end
    tick();
    @(negedge clock);
    check("t4_abort", {lsu_done, lsu_err, lsu_rdata}, {2'b11, 32'h0});
    tick();
    lsu_req = 1'b0;
    @(negedge clock);
    check("t4_idle", {lsu_grant, mem_valid}, 2'b00);
    tick();
    tick();
    mem_resp_valid = 1'b1;
    @(negedge clock);
    check("t4_stray", {ifu_done, lsu_done}, 2'b00);
    tick();
    mem_resp_valid = 1'b0; mem_rdata = '0;

    // Reset while waiting in the data phase.
    tick();
    ifu_req = 1'b1; ifu_addr = 32'h8000_0040;
    tick();
    mem_ready = 1'b1;
    @(negedge clock);
    check("t5_grant", ifu_grant, 1'b1);
    tick();
    mem_ready = 1'b0;
    @(negedge clock);
    check("t5_data", {ifu_grant, mem_valid}, 2'b10);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_nodone", ifu_done, 1'b0);
    tick();
    reset = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0077;
    @(negedge clock);
    check("t5_after_rst", |{ifu_done, ifu_rdata, ifu_err, ifu_grant, lsu_done, lsu_rdata,
                            lsu_err, lsu_grant, mem_valid, mem_we, mem_addr, mem_wdata,
                            mem_wmask}, 1'b0);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clock);
    check("t5_reserve", {ifu_grant, ifu_done, ifu_err, ifu_rdata}, {3'b110, 32'h0BAD_F00D});
    tick();
    ifu_req = 1'b0; mem_ready = 1'b0; mem_resp_valid = 1'b0;

    // Zero-wait bus with an error response.
    tick();
    ifu_req = 1'b1; ifu_addr = 32'h8000_0080;
    mem_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_rdata = 32'h11;
    tick();
    @(negedge clock);
    check("t6_zw_err", {ifu_grant, ifu_done, ifu_err, mem_valid}, 4'b1111);
    tick();
    ifu_req = 1'b0; mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;

    // Randomised masters and bus; masters hold requests until their done.
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if (ifu_req && m_ifu_done_prev) ifu_req = 1'b0;
      else if (!ifu_req && $urandom_range(0, 2) == 0) begin
        ifu_req = 1'b1; ifu_addr = $urandom;
      end
      if (lsu_req && m_lsu_done_prev) lsu_req = 1'b0;
      else if (!lsu_req && $urandom_range(0, 2) == 0) begin
        lsu_req = 1'b1; lsu_we = $urandom_range(0, 1) == 1;
        lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'($urandom_range(0, 15));
      end
      mem_ready      = $urandom_range(0, 1) == 1;
      mem_resp_valid = $urandom_range(0, 2) == 0;
      mem_rdata      = $urandom;
      mem_resp_err   = $urandom_range(0, 7) == 0;
    end
    tick();
    reset = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0;
    tick();
    tick();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_bus_arbiter.md
# ysyx_23060184_bus_arbiter

Two-master, one-slave arbiter that shares the core's single memory bus between the IFU and the LSU. It sits in front of the LSU address crossbar. Its `lsu_grant` output qualifies the crossbar's SoC/CLINT routing. It holds one transaction at a time, alternates priority on contention, and aborts hung transactions with an error response through a watchdog.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: cycles allowed from grant to response before abort. Must be at least 2.

Ports:
- `clock` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `ifu_req` in 1: IFU read request. Held together with `ifu_addr` until `ifu_done`.
- `ifu_addr` in ADDR_W: IFU fetch address.
- `ifu_done` out 1: one-cycle response pulse to the IFU.
- `ifu_rdata` out DATA_W: IFU read data, valid while `ifu_done` is high.
- `ifu_err` out 1: IFU error flag, valid while `ifu_done` is high.
- `ifu_grant` out 1: IFU owns the bus.
- `lsu_req` in 1: LSU request. Held together with its fields until `lsu_done`.
- `lsu_we` in 1: LSU write enable.
- `lsu_addr` in ADDR_W: LSU address.
- `lsu_wdata` in DATA_W: LSU write data.
- `lsu_wmask` in DATA_W/8: LSU byte mask.
- `lsu_done` out 1: one-cycle response pulse to the LSU.
- `lsu_rdata` out DATA_W: LSU read data, valid while `lsu_done` is high.
- `lsu_err` out 1: LSU error flag, valid while `lsu_done` is high.
- `lsu_grant` out 1: LSU owns the bus. Feeds the LSU crossbar.
- `mem_valid` out 1: request valid to the bus.
- `mem_we` out 1: write enable to the bus.
- `mem_addr` out ADDR_W: address to the bus.
- `mem_wdata` out DATA_W: write data to the bus.
- `mem_wmask` out DATA_W/8: byte mask to the bus.
- `mem_ready` in 1: bus accepts the request.
- `mem_resp_valid` in 1: read data or write acknowledge from the bus.
- `mem_rdata` in DATA_W: read data from the bus.
- `mem_resp_err` in 1: bus error.

## Operation
FSM states: `IDLE`, `ADDR`, `DATA`.

IDLE:
- If neither master requests, stay in IDLE.
- If exactly one master requests, grant it and go to ADDR.
- If both request, grant the master that is not `last_grant`. `last_grant` resets to IFU, so the first tie after reset goes to the LSU. A grant updates `last_grant`.

ADDR:
- Assert `mem_valid`.
- Drive `mem_*` combinationally from the winner's fields. When the IFU wins, `mem_we`=0 and `mem_wmask`=0.
- Leave for DATA on `mem_valid && mem_ready`.
- If `mem_resp_valid` arrives in that same cycle, complete directly as described under DATA.

DATA:
- `mem_valid` is 0.
- On `mem_resp_valid`, pulse the winner's `*_done`, pass `mem_rdata` and `mem_resp_err` to that master, and go to IDLE.

Grants:
- Registered and one-hot.
- High from entry to ADDR through the `*_done` cycle inclusive.
- Never both high.

Watchdog:
- Counter `wd_cnt` has width clog2(TIMEOUT+1). It clears on the IDLE→ADDR transition and increments every cycle spent in ADDR or DATA.
- When `wd_cnt == TIMEOUT-1` and the transaction has not completed that cycle, pulse the owner's `*_done` with `*_err`=1 and `*_rdata`=0, and go to IDLE.
- Genuine completion in that same cycle takes precedence over the abort.

Other rules:
- Any `mem_resp_valid` seen in IDLE is a stray response from an aborted transaction. It is ignored and no `done` pulse is generated.
- A requester that drops `*_req` before `*_done` is a protocol violation. Its behaviour is unspecified, and the bench flags it.
- `*_rdata` and `*_err` are 0 whenever `*_done` is 0.

## Timing
- Reset values: state=IDLE, `last_grant`=IFU, `wd_cnt`=0. Every output is 0.
- Reset in mid-transaction returns the block to IDLE on the next edge. No `done` pulse is issued for the killed transaction, and a later response to it is dropped as a stray.
- Latency: `*_req` is sampled in IDLE at cycle 0. The grant and `mem_valid` rise at cycle 1. With a zero-wait bus (`mem_ready` and `mem_resp_valid` both high at cycle 1), `*_done` pulses at cycle 1.
- Turnaround: after a `done` at cycle N, the block is in IDLE at N+1 and the next grant rises no earlier than N+2.
- `*_done` is combinational from `mem_resp_valid` in the owning state. `grant` and `mem_valid` are registered or state-decoded, and have no combinational path from `mem_ready`.

## Structure
- The `` `DATA_W ``/`` `ADDR_W `` defines, the state encoding, and the default TIMEOUT go in the shared defines header beside the CLINT address-range defines.
- One sub-module, `ysyx_23060184_bus_watchdog`: the counter with clear, enable and `expire` outputs, parameterised by TIMEOUT.
- Everything else stays in this block.

## Test plan
- IFU alone, `addr`=0x8000_0000, `mem_ready` high one cycle after `mem_valid`, response 2 cycles later with `rdata`=0xDEADBEEF → `ifu_grant` rises at cycle 1, `ifu_done` pulses with 0xDEADBEEF and err=0, `lsu_grant` stays 0 throughout.
- Both masters request at the first tie after reset → LSU is served first and IFU next. Sustained dual requests → grants alternate LSU, IFU, LSU, IFU, with one IDLE cycle between consecutive transactions.
- LSU write, `addr`=0x0200_0000, `wdata`=0x1234, `wmask`=0x3 → `mem_we`=1 and the `mem_*` fields match exactly. `lsu_done` pulses on the ack.
- TIMEOUT=8 and the bus never responds → `lsu_done` pulses with err=1 and `rdata`=0 at `wd_cnt`=7, then the block is in IDLE. A response injected 3 cycles later produces no `done` pulse.
- Reset asserted while in DATA → the next cycle shows all outputs at 0 and state IDLE, and a following IFU request is served normally.
- Zero-wait bus (`mem_ready` and `mem_resp_valid` both high in the grant cycle) → `done` pulses in the grant cycle. `mem_resp_err`=1 in that cycle propagates to `*_err`=1.
